pwm_multichannel: RTL and testbench
===================================

# pwm_multichannel

Parametrised multi-channel PWM generator with complementary outputs. It succeeds the single-channel 8-bit generator. It adds:
- N channels sharing one time base
- programmable period
- edge- or center-aligned counting
- double-buffered duty registers, updated glitch-free at period boundaries
- per-channel dead-time insertion for half-bridge drivers

It sits between the register/IO front end (`ui_in` decode) and the `uo_out` pins of the top-level wrapper.

## Interface
Parameters:
- `CNT_W`, 8, counter/period/duty width
- `NCH`, 4, channel count (≥1)
- `DT_W`, 4, dead-time field width

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-low
- `enable`  in  1  run; low holds counter at 0 and forces all outputs low
- `period`  in  `CNT_W`  period value P, sampled at boundary
- `center_mode`  in  1  0 = edge-aligned, 1 = center-aligned, sampled at boundary
- `deadtime`  in  `DT_W`  dead-time DT in clk cycles, sampled at boundary
- `wr_en`  in  1  duty write strobe
- `wr_ch`  in  `max(1,$clog2(NCH))`  target channel; values ≥ `NCH` are ignored
- `wr_duty`  in  `CNT_W`  duty value D
- `pwm_hi`  out  `NCH`  high-side outputs
- `pwm_lo`  out  `NCH`  low-side (complementary) outputs
- `period_start`  out  1  one-cycle pulse aligned with the first output cycle of each period

## Operation
- **Reset:** all of the following are 0 and the count direction is up:
  - counter
  - shadow and active duties
  - latched P, mode and DT
  - `pwm_hi`, `pwm_lo`, `period_start`
- **Counter, edge mode:** 0,1,…,P,0,… giving a period of P+1 cycles.
- **Counter, center mode:** up 0…P, then down P−1…1, then 0, giving a period of 2P cycles.
- **P = 0:** the counter stays at 0 and every cycle is a boundary.
- **Boundary:** the cycle in which counter = 0 with enable high. At a boundary:
  - P, mode and DT are latched.
  - Each channel loads active ← shadow.
  - A `wr_en` to that channel in the same cycle wins; `wr_duty` goes to both shadow and active.
- **Writes:** when `wr_en` is high and `wr_ch` < `NCH`, shadow[wr_ch] ← `wr_duty`. Writes are accepted regardless of `enable`. There is no back-pressure.
- **Compare:** raw[ch] = (counter < active[ch]).
  - D = 0 gives constant low.
  - D > P gives constant high (edge mode); D ≥ P gives constant high (center mode).
- **Dead-time, per channel:**
  - Raw rising: `pwm_lo` drops immediately; `pwm_hi` rises after DT cycles.
  - Raw falling: `pwm_hi` drops immediately; `pwm_lo` rises after DT cycles.
  - If raw reverses during a dead-time window, the wait restarts for the new direction. Both outputs stay low until it expires.
  - If D ≤ DT, `pwm_hi` never asserts.
  - With DT = 0, `pwm_lo` = ~`pwm_hi`.
- **Invariant:** `pwm_hi[ch]` & `pwm_lo[ch]` is never 1, including across reset, enable and mode changes.
- **Enable falling:** outputs go low the next cycle and the counter resets to 0. Dead-time state clears.
- **Enable rising:** the first cycle is a boundary.
- **Reset mid-period:** outputs low asynchronously. Programmed duties are lost.

## Timing
- **Pipeline:** counter → registered compare → registered dead-time/output stage.
- **Latency:** output reflects the counter value 2 cycles later.
- `period_start` is delayed by the same 2 cycles, so it coincides with the first output cycle of the period.
- **Edge mode, DT = 0:** `pwm_hi` high for exactly min(D, P+1) of every P+1 cycles, starting at `period_start`.
- **With DT > 0:** `pwm_hi` high-time is D−DT. `pwm_lo` high-time is P+1−D−DT.
- **Duty update latency:** a write takes effect at the next boundary. Outputs show it 2 cycles after that boundary. A period in progress is never altered.
- **Enable falling:** outputs low 1 cycle after the `enable` edge. They are not pipelined, and this overrides the 2-cycle path.

## Structure
- **Package `pwm_pkg`:**
  - `mode_e` {`MODE_EDGE`, `MODE_CENTER`}
  - `dir_e` {`DIR_UP`, `DIR_DOWN`}
  - default `CNT_W`/`NCH`/`DT_W` constants
  - dead-time FSM state enum {`DT_LO`, `DT_WAIT_HI`, `DT_HI`, `DT_WAIT_LO`}
- **Sub-module `pwm_deadtime`:** one per channel via generate. Inputs raw, DT, enable; outputs `pwm_hi`/`pwm_lo`. It contains the 4-state FSM and a `DT_W` down-counter.
- **Top level:** the counter, boundary logic, shadow/active duty arrays and compare live in `pwm_multichannel`.

## Test plan
- **Edge, basic:** P=9, D={0,3,9,10}, DT=0 → `pwm_hi` high-time per 10-cycle period = 0, 3, 9, 10. `period_start` every 10 cycles.
- **Center:** P=8, D=4 → period 16, `pwm_hi` high for 8 cycles, centered on counter = 0.
- **Dead-time:** P=15, D=8, DT=3 → `pwm_hi` high 5 cycles, `pwm_lo` high 5 cycles, 3-cycle both-low gaps. D=2, DT=3 → `pwm_hi` never high. Overlap checker is active throughout.
- **Double buffering:** write ch1 D=6 mid-period (P=9) → current period unchanged, next period 6 high. Write exactly on the boundary cycle → takes effect that period.
- **Control edges:** `wr_ch`=`NCH` is ignored. Deassert `enable` mid-high → outputs low next cycle. Reassert → `period_start` 2 cycles later.
- **Reset mid-operation:** assert `reset` low asynchronously while `pwm_hi`=1 → all outputs 0 immediately. After release, duties read as 0 (outputs `pwm_lo` only).

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and default sizes for the multi-channel PWM generator.
package pwm_pkg;

    localparam int unsigned DEFAULT_CNT_W = 8;
    localparam int unsigned DEFAULT_NCH   = 4;
    localparam int unsigned DEFAULT_DT_W  = 4;

    typedef enum logic {MODE_EDGE, MODE_CENTER} mode_e;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
    typedef enum logic [1:0] {DT_LO, DT_WAIT_HI, DT_HI, DT_WAIT_LO} dt_state_e;

endpackage

// File: rtl/pwm_deadtime.sv
// Per-channel dead-time inserter: turns the raw compare into a non-overlapping hi/lo pair.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int unsigned DT_W = DEFAULT_DT_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            raw,
    input  logic [DT_W-1:0] dt,
    output logic            pwm_hi,
    output logic            pwm_lo
);

    dt_state_e       state_q;
    logic [DT_W-1:0] wait_q;

    // Idle parks in DT_WAIT_LO with an expired count so pwm_lo comes up one cycle after enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DT_WAIT_LO;
            wait_q  <= '0;
            pwm_hi  <= 1'b0;
            pwm_lo  <= 1'b0;
        end else if (!enable) begin
            state_q <= DT_WAIT_LO;
            wait_q  <= '0;
            pwm_hi  <= 1'b0;
            pwm_lo  <= 1'b0;
        end else begin
            unique case (state_q)
                DT_LO: begin
                    if (raw) begin
                        pwm_lo <= 1'b0;
                        if (dt == '0) begin
                            state_q <= DT_HI;
                            pwm_hi  <= 1'b1;
                        end else begin
                            state_q <= DT_WAIT_HI;
                            wait_q  <= dt - DT_W'(1);
                        end
                    end
                end
                DT_WAIT_HI: begin
                    if (!raw) begin
                        if (dt == '0) begin
                            state_q <= DT_LO;
                            pwm_lo  <= 1'b1;
                        end else begin
                            state_q <= DT_WAIT_LO;
                            wait_q  <= dt - DT_W'(1);
                        end
                    end else if (wait_q == '0) begin
                        state_q <= DT_HI;
                        pwm_hi  <= 1'b1;
                    end else begin
                        wait_q <= wait_q - DT_W'(1);
                    end
                end
                DT_HI: begin
                    if (!raw) begin
                        pwm_hi <= 1'b0;
                        if (dt == '0) begin
                            state_q <= DT_LO;
                            pwm_lo  <= 1'b1;
                        end else begin
                            state_q <= DT_WAIT_LO;
                            wait_q  <= dt - DT_W'(1);
                        end
                    end
                end
                DT_WAIT_LO: begin
                    if (raw) begin
                        if (dt == '0) begin
                            state_q <= DT_HI;
                            pwm_hi  <= 1'b1;
                        end else begin
                            state_q <= DT_WAIT_HI;
                            wait_q  <= dt - DT_W'(1);
                        end
                    end else if (wait_q == '0) begin
                        state_q <= DT_LO;
                        pwm_lo  <= 1'b1;
                    end else begin
                        wait_q <= wait_q - DT_W'(1);
                    end
                end
                default: begin
                    state_q <= DT_WAIT_LO;
                    wait_q  <= '0;
                    pwm_hi  <= 1'b0;
                    pwm_lo  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_multichannel.sv
// N-channel PWM: shared edge/center counter, double-buffered duties, registered compare,
// and per-channel dead-time output stage.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W,
    parameter int unsigned NCH   = DEFAULT_NCH,
    parameter int unsigned DT_W  = DEFAULT_DT_W,
    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    input  logic             center_mode,
    input  logic [DT_W-1:0]  deadtime,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_duty,
    output logic [NCH-1:0]   pwm_hi,
    output logic [NCH-1:0]   pwm_lo,
    output logic             period_start
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_e             dir_q, dir_d;
    logic [CNT_W-1:0] period_q;
    mode_e            mode_q;
    logic [DT_W-1:0]  dt_q;
    logic [CNT_W-1:0] shadow_q [NCH];
    logic [CNT_W-1:0] active_q [NCH];
    logic [CNT_W-1:0] active_d [NCH];
    logic [NCH-1:0]   wr_hit;
    logic [NCH-1:0]   raw_q, raw_d;
    logic             ps_q;
    logic             boundary;
    logic             down_half;
    logic [CNT_W-1:0] per_eff;
    mode_e            mode_eff;

    // Boundary cycle uses the freshly sampled controls so the new period starts immediately.
    assign boundary = enable && (cnt_q == '0);
    assign per_eff  = boundary ? period : period_q;
    assign mode_eff = boundary ? mode_e'(center_mode) : mode_q;

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!enable || (per_eff == '0)) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (mode_eff == MODE_EDGE) begin
            dir_d = DIR_UP;
            cnt_d = (cnt_q >= per_eff) ? '0 : cnt_q + CNT_W'(1);
        end else if (dir_q == DIR_UP) begin
            if (cnt_q >= per_eff) begin
                cnt_d = per_eff - CNT_W'(1);
                dir_d = (per_eff == CNT_W'(1)) ? DIR_UP : DIR_DOWN;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) dir_d = DIR_UP;
        end
    end

    // The peak and falling half compare inclusively so center mode is high for 2*D of 2*P.
    always_comb begin
        wr_hit    = '0;
        raw_d     = '0;
        down_half = (mode_q == MODE_CENTER) && (cnt_q != '0) &&
                    ((dir_q == DIR_DOWN) || (cnt_q == period_q));
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i]   = wr_en && (wr_ch == CH_W'(i));
            active_d[i] = active_q[i];
            if (boundary) active_d[i] = wr_hit[i] ? wr_duty : shadow_q[i];
            raw_d[i] = enable && (down_half ? (cnt_q <= active_d[i]) : (cnt_q < active_d[i]));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            dir_q        <= DIR_UP;
            period_q     <= '0;
            mode_q       <= MODE_EDGE;
            dt_q         <= '0;
            raw_q        <= '0;
            ps_q         <= 1'b0;
            period_start <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            if (boundary) begin
                period_q <= period;
                mode_q   <= mode_e'(center_mode);
                dt_q     <= deadtime;
            end
            for (int i = 0; i < NCH; i++) begin
                if (wr_hit[i]) shadow_q[i] <= wr_duty;
                active_q[i] <= active_d[i];
            end
            raw_q        <= raw_d;
            ps_q         <= boundary;
            period_start <= ps_q && enable;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pwm_deadtime #(
            .DT_W (DT_W)
        ) u_deadtime (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .raw    (raw_q[g]),
            .dt     (dt_q),
            .pwm_hi (pwm_hi[g]),
            .pwm_lo (pwm_lo[g])
        );
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: 4-channel main instance plus a 3-channel one for wr_ch range.
module tb_pwm_multichannel;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] period;
    logic       center_mode;
    logic [3:0] deadtime;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_duty;
    logic [3:0] pwm_hi;
    logic [3:0] pwm_lo;
    logic       period_start;
    logic [2:0] hi3;
    logic [2:0] lo3;
    logic       ps3;

    int n_cmp = 0;
    int n_err = 0;
    int overlaps = 0;
    int hi_cnt [4];
    int lo_cnt [4];
    int bl_cnt [4];
    int hi3_cnt [3];
    int ps_cnt;
    logic [31:0] map0;

    pwm_multichannel #(
        .CNT_W (8),
        .NCH   (4),
        .DT_W  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .period       (period),
        .center_mode  (center_mode),
        .deadtime     (deadtime),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_duty      (wr_duty),
        .pwm_hi       (pwm_hi),
        .pwm_lo       (pwm_lo),
        .period_start (period_start)
    );

    pwm_multichannel #(
        .CNT_W (8),
        .NCH   (3),
        .DT_W  (4)
    ) dut3 (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .period       (period),
        .center_mode  (center_mode),
        .deadtime     (deadtime),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_duty      (wr_duty),
        .pwm_hi       (hi3),
        .pwm_lo       (lo3),
        .period_start (ps3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (((pwm_hi & pwm_lo) != 4'b0) || ((hi3 & lo3) != 3'b0)) overlaps++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_write(input int ch, input int duty);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_ch   = ch[1:0];
        wr_duty = duty[7:0];
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic wait_ps(input int lim);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!period_start && k < lim);
        check("ps_seen", period_start, 1);
    endtask

    // Sample n negedges (first one immediately if now); optionally pulse a write after sample wr_at.
    task automatic measure(input int n, input bit now, input int wr_at, input int ch,
                           input int duty);
        for (int i = 0; i < 4; i++) begin
            hi_cnt[i] = 0;
            lo_cnt[i] = 0;
            bl_cnt[i] = 0;
        end
        for (int i = 0; i < 3; i++) hi3_cnt[i] = 0;
        ps_cnt = 0;
        map0   = '0;
        for (int k = 0; k < n; k++) begin
            if (k > 0 || !now) @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (pwm_hi[i]) hi_cnt[i]++;
                if (pwm_lo[i]) lo_cnt[i]++;
                if (!pwm_hi[i] && !pwm_lo[i]) bl_cnt[i]++;
            end
            for (int i = 0; i < 3; i++) if (hi3[i]) hi3_cnt[i]++;
            if (period_start) ps_cnt++;
            if (k < 32) map0[k] = pwm_hi[0];
            if (k == wr_at) begin
                wr_en   = 1'b1;
                wr_ch   = ch[1:0];
                wr_duty = duty[7:0];
                @(posedge clk);
                #1 wr_en = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed 0, expected 1");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b0; enable = 1'b0; center_mode = 1'b0; period = 8'd0; deadtime = 4'd0;
        wr_en = 1'b0; wr_ch = 2'd0; wr_duty = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_hi", pwm_hi, 0);
        check("rst_lo", pwm_lo, 0);
        check("rst_ps", period_start, 0);

        // Edge mode, P=9, D={0,3,9,10}, DT=0; writes land while disabled
        reset  = 1'b1;
        period = 8'd9;
        do_write(0, 0);
        do_write(1, 3);
        do_write(2, 9);
        do_write(3, 10);
        @(negedge clk);
        check("dis_outs", {hi3, lo3, pwm_lo, pwm_hi}, 0);
        enable = 1'b1;
        @(negedge clk);
        check("en_ps_early", period_start, 0);
        @(negedge clk);
        check("en_ps", period_start, 1);
        measure(10, 1'b1, -1, 0, 0);
        check("edge_hi0", hi_cnt[0], 0);
        check("edge_hi1", hi_cnt[1], 3);
        check("edge_hi2", hi_cnt[2], 9);
        check("edge_hi3", hi_cnt[3], 10);
        check("edge_lo1", lo_cnt[1], 7);
        check("edge_lo2", lo_cnt[2], 1);
        check("edge_map0", map0[9:0], 0);
        check("n3_hi0", hi3_cnt[0], 0);
        check("n3_hi1", hi3_cnt[1], 3);
        check("n3_hi2", hi3_cnt[2], 9);
        measure(30, 1'b0, -1, 0, 0);
        check("edge_ps_rate", ps_cnt, 3);

        // Center mode, P=8
        period      = 8'd8;
        center_mode = 1'b1;
        do_write(0, 4);
        repeat (3) wait_ps(100);
        measure(16, 1'b1, -1, 0, 0);
        check("ctr_map0", map0[15:0], 32'h0000_F00F);
        check("ctr_hi0", hi_cnt[0], 8);
        check("ctr_lo0", lo_cnt[0], 8);
        check("ctr_hi1", hi_cnt[1], 6);
        check("ctr_hi2", hi_cnt[2], 16);
        check("ctr_ps", ps_cnt, 1);

        // Dead-time, P=15, DT=3: D=8 and D=2
        period      = 8'd15;
        center_mode = 1'b0;
        deadtime    = 4'd3;
        do_write(0, 8);
        do_write(1, 2);
        repeat (3) wait_ps(100);
        measure(16, 1'b1, -1, 0, 0);
        check("dt_hi0", hi_cnt[0], 5);
        check("dt_lo0", lo_cnt[0], 5);
        check("dt_gap0", bl_cnt[0], 6);
        check("dt_map0", map0[15:0], 32'h0000_00F8);
        check("dt_hi1", hi_cnt[1], 0);
        check("dt_lo1", lo_cnt[1], 11);

        // Double buffering on ch1, P=9, DT=0
        period   = 8'd9;
        deadtime = 4'd0;
        do_write(1, 3);
        repeat (3) wait_ps(100);
        measure(10, 1'b1, 4, 1, 6);
        check("db_mid_keep", hi_cnt[1], 3);
        measure(10, 1'b0, 8, 1, 9);
        check("db_mid_next", hi_cnt[1], 6);
        check("db_ps", ps_cnt, 1);
        measure(10, 1'b0, 9, 1, 1);
        check("db_on_bnd", hi_cnt[1], 9);
        measure(10, 1'b0, -1, 0, 0);
        check("db_after_bnd", hi_cnt[1], 9);
        measure(10, 1'b0, -1, 0, 0);
        check("db_late", hi_cnt[1], 1);

        // Enable drop while ch2 is high, then re-enable
        wait_ps(100);
        repeat (2) @(negedge clk);
        check("pre_dis_hi2", pwm_hi[2], 1);
        enable = 1'b0;
        @(negedge clk);
        check("dis_hi", pwm_hi, 0);
        check("dis_lo", pwm_lo, 0);
        check("dis_n3", {hi3, lo3}, 0);
        repeat (3) @(negedge clk);
        check("dis_hold", {period_start, pwm_lo, pwm_hi}, 0);
        enable = 1'b1;
        @(negedge clk);
        check("reen_ps_early", period_start, 0);
        @(negedge clk);
        check("reen_ps", period_start, 1);
        check("reen_hi2", pwm_hi[2], 1);

        // Asynchronous reset while pwm_hi is high
        #2 reset = 1'b0;
        #1;
        check("arst_hi", pwm_hi, 0);
        check("arst_lo", pwm_lo, 0);
        check("arst_n3", {ps3, hi3, lo3}, 0);
        @(negedge clk);
        reset = 1'b1;
        wait_ps(100);
        measure(10, 1'b1, -1, 0, 0);
        check("post_rst_hi", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);
        check("post_rst_lo0", lo_cnt[0], 10);
        check("post_rst_lo2", lo_cnt[2], 10);
        check("post_rst_lo3", lo_cnt[3], 10);
        check("post_rst_n3", hi3_cnt[2], 0);

        check("overlap", overlaps, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
